fetch_decode_pipe: RTL and testbench

Parametrised fetch-to-decode pipeline stage carrying PC, instruction and a sideband field between the fetch and decode units of the RAPID-X core. It generalises the plain IF/ID register in three ways: valid/ready handshaking on both sides, a two-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/trap redirect. Empty slots present a NOP instruction to decode.

---
 rtl/rapid_pkg.sv | 20 ++
 rtl/pipe_payload_reg.sv | 21 ++
 rtl/fetch_decode_pipe.sv | 108 ++++++++++
 tb/tb_fetch_decode_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared RAPID-X core widths, NOP encoding and fetch/decode types
package rapid_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int FD_SB_W = 4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    instruction;
    logic [FD_SB_W-1:0] sb;
  } fd_payload_t;

  typedef enum logic [1:0] {
    FD_EMPTY = 2'd0,
    FD_ONE   = 2'd1,
    FD_TWO   = 2'd2
  } fd_state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - load-enabled payload register with async active-low reset
module pipe_payload_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_pipe.sv
// rtl/fetch_decode_pipe.sv - fetch-to-decode stage with two-entry skid buffer and flush
module fetch_decode_pipe #(
  parameter int                 XLEN     = rapid_pkg::XLEN,
  parameter int                 SB_W     = 4,
  parameter logic [XLEN-1:0]    NOP_INSN = rapid_pkg::NOP_INSN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instruction,
  input  logic [SB_W-1:0] i_sb,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic [SB_W-1:0] o_sb,
  output logic [1:0]      o_occupancy
);

  import rapid_pkg::*;

  localparam int PW = 2 * XLEN + SB_W;
  localparam logic [PW-1:0] MAIN_RST = {{XLEN{1'b0}}, NOP_INSN, {SB_W{1'b0}}};

  fd_state_t       state, state_nxt;
  logic            in_fire, out_fire;
  logic            main_load, skid_load;
  logic [PW-1:0]   in_payload, main_d, main_q, skid_q;

  // Ready and valid come from the state register alone, so i_ready never reaches o_ready.
  assign o_ready     = (state != FD_TWO);
  assign o_valid     = (state != FD_EMPTY);
  assign o_occupancy = state;
  assign in_fire     = i_valid & o_ready;
  assign out_fire    = o_valid & i_ready;
  assign in_payload  = {i_pc, i_instruction, i_sb};

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_payload;
    if (i_flush) begin
      state_nxt = FD_EMPTY;
    end else begin
      case (state)
        FD_EMPTY: begin
          if (in_fire) begin
            state_nxt = FD_ONE;
            main_load = 1'b1;
          end
        end
        FD_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_nxt = FD_TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_nxt = FD_EMPTY;
          end
        end
        FD_TWO: begin
          // Skid entry is always younger than main, so it promotes on consumption.
          if (out_fire) begin
            state_nxt = FD_ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_nxt = FD_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= FD_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  pipe_payload_reg #(.W(PW), .RST_VAL(MAIN_RST)) u_main (
    .clk   (i_clk),
    .rst_n (i_reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.W(PW), .RST_VAL('0)) u_skid (
    .clk   (i_clk),
    .rst_n (i_reset),
    .load  (skid_load),
    .d     (in_payload),
    .q     (skid_q)
  );

  // Empty slots show a NOP with clear sideband; the PC keeps its last loaded value.
  assign o_pc          = main_q[PW-1 -: XLEN];
  assign o_instruction = o_valid ? main_q[SB_W +: XLEN] : NOP_INSN;
  assign o_sb          = o_valid ? main_q[SB_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// tb/tb_fetch_decode_pipe.sv - directed and scoreboard bench for fetch_decode_pipe
module tb_fetch_decode_pipe;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid, o_ready, i_flush, o_valid, i_ready;
  logic [31:0] i_pc, i_instruction, o_pc, o_instruction;
  logic [3:0]  i_sb, o_sb;
  logic [1:0]  o_occupancy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [3:0]  sb;
  } ent_t;

  fetch_decode_pipe dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_pc          (i_pc),
    .i_instruction (i_instruction),
    .i_sb          (i_sb),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_sb          (o_sb),
    .o_occupancy   (o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    i_valid       = v;
    i_pc          = pc;
    i_instruction = pc + 32'h00a0_0093;
    i_sb          = pc[5:2];
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    offer(1'b0, 32'h0);
    #12;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    checks++; if (o_occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", o_occupancy); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
    checks++; if (o_instruction !== NOP) begin errors++; $display("FAIL reset_insn: got %h expected %h", o_instruction, NOP); end
    checks++; if (o_sb !== 4'h0) begin errors++; $display("FAIL reset_sb: got %h expected 0", o_sb); end
    @(posedge clk);
    #1 i_reset = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [100];
    for (int k = 0; k < 100; k++) pcs[k] = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    i_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      offer(1'b1, pcs[k]);
      tick();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, o_valid); end
      checks++; if (o_pc !== pcs[k]) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, o_pc, pcs[k]); end
      checks++; if (o_instruction !== pcs[k] + 32'h00a0_0093) begin errors++; $display("FAIL stream_insn[%0d]: got %h expected %h", k, o_instruction, pcs[k] + 32'h00a0_0093); end
    end
    offer(1'b0, 32'h0);
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b expected 0", o_valid); end
    checks++; if (o_instruction !== NOP) begin errors++; $display("FAIL stream_drain_nop: got %h expected %h", o_instruction, NOP); end
    checks++; if (o_pc !== pcs[99]) begin errors++; $display("FAIL stream_pc_hold: got %h expected %h", o_pc, pcs[99]); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    offer(1'b1, 32'h200);
    tick();
    checks++; if (o_pc !== 32'h200 || o_occupancy !== 2'd1 || o_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got pc %h occ %0d rdy %b expected 200 1 1", o_pc, o_occupancy, o_ready); end
    offer(1'b1, 32'h204);
    tick();
    checks++; if (o_pc !== 32'h200 || o_occupancy !== 2'd2 || o_ready !== 1'b0) begin errors++; $display("FAIL bp_skid: got pc %h occ %0d rdy %b expected 200 2 0", o_pc, o_occupancy, o_ready); end
    offer(1'b1, 32'h208);
    tick();
    checks++; if (o_pc !== 32'h200 || o_occupancy !== 2'd2 || o_sb !== 4'h0) begin errors++; $display("FAIL bp_hold: got pc %h occ %0d sb %h expected 200 2 0", o_pc, o_occupancy, o_sb); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h204 || o_occupancy !== 2'd1) begin errors++; $display("FAIL bp_drain1: got pc %h occ %0d expected 204 1", o_pc, o_occupancy); end
    tick();
    checks++; if (o_pc !== 32'h208 || o_valid !== 1'b1 || o_sb !== 4'h2) begin errors++; $display("FAIL bp_drain2: got pc %h v %b sb %h expected 208 1 2", o_pc, o_valid, o_sb); end
    offer(1'b0, 32'h0);
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    offer(1'b1, 32'h280);
    tick();
    offer(1'b1, 32'h284);
    tick();
    offer(1'b1, 32'h300);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_two: got v %b occ %0d rdy %b expected 0 0 1", o_valid, o_occupancy, o_ready); end
    checks++; if (o_instruction !== NOP) begin errors++; $display("FAIL flush_nop: got %h expected %h", o_instruction, NOP); end
    offer(1'b1, 32'h400);
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h400) begin errors++; $display("FAIL flush_next: got v %b pc %h expected 1 400", o_valid, o_pc); end
    // flush while an entry is really accepted in ONE: it must be dropped
    i_ready = 1'b0;
    offer(1'b1, 32'h504);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    offer(1'b0, 32'h0);
    checks++; if (o_valid !== 1'b0 || o_pc !== 32'h400) begin errors++; $display("FAIL flush_one_drop: got v %b pc %h expected 0 400", o_valid, o_pc); end
    tick();
    checks++; if (o_occupancy !== 2'd0) begin errors++; $display("FAIL flush_one_occ: got %0d expected 0", o_occupancy); end
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b0;
    offer(1'b1, 32'h100);
    tick();
    offer(1'b1, 32'h104);
    tick();
    offer(1'b0, 32'h0);
    checks++; if (o_occupancy !== 2'd2) begin errors++; $display("FAIL rst_mid_pre: got %0d expected 2", o_occupancy); end
    #2 i_reset = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_vr: got v %b rdy %b expected 0 1", o_valid, o_ready); end
    checks++; if (o_instruction !== NOP || o_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_out: got insn %h pc %h expected %h 0", o_instruction, o_pc, NOP); end
    tick();
    i_reset = 1'b1;
    tick();
    checks++; if (o_occupancy !== 2'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_post: got occ %0d v %b expected 0 0", o_occupancy, o_valid); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] last_pc = 32'h0;
    logic        m_in, m_out;
    for (int c = 0; c < 10000; c++) begin
      i_valid       = ($urandom_range(0, 9) < 7);
      i_ready       = ($urandom_range(0, 9) < 6);
      i_flush       = ($urandom_range(0, 99) < 4);
      i_pc          = $urandom;
      i_instruction = $urandom;
      i_sb          = 4'($urandom);
      checks++; if (o_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, o_valid, q.size() > 0); end
      checks++; if (o_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, o_ready, q.size() < 2); end
      checks++; if (o_occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ c%0d: got %0d expected %0d", c, o_occupancy, q.size()); end
      if (q.size() > 0) begin
        checks++; if (o_pc !== q[0].pc || o_instruction !== q[0].insn || o_sb !== q[0].sb) begin errors++; $display("FAIL rnd_data c%0d: got %h/%h/%h expected %h/%h/%h", c, o_pc, o_instruction, o_sb, q[0].pc, q[0].insn, q[0].sb); end
      end else begin
        checks++; if (o_pc !== last_pc || o_instruction !== NOP || o_sb !== 4'h0) begin errors++; $display("FAIL rnd_empty c%0d: got %h/%h/%h expected %h/%h/0", c, o_pc, o_instruction, o_sb, last_pc, NOP); end
      end
      m_in  = i_valid && (q.size() < 2);
      m_out = (q.size() > 0) && i_ready;
      e.pc = i_pc; e.insn = i_instruction; e.sb = i_sb;
      tick();
      if (i_flush) begin
        q.delete();
      end else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back(e);
        if (q.size() > 0) last_pc = q[0].pc;
      end
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
